// File: rtl/nec_ir_pkg.sv
// nec_ir_pkg: FSM state encoding and NEC timing windows, in eighth-tick units (E).
package nec_ir_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP, S_REPEAT
  } state_e;
  localparam logic [7:0] E_SAT          = 8'd255;
  localparam logic [7:0] LEAD_MARK_MIN  = 8'd112;
  localparam logic [7:0] LEAD_MARK_MAX  = 8'd144;
  localparam logic [7:0] LEAD_SPACE_MIN = 8'd56;
  localparam logic [7:0] LEAD_SPACE_MAX = 8'd72;
  localparam logic [7:0] REP_SPACE_MIN  = 8'd28;
  localparam logic [7:0] REP_SPACE_MAX  = 8'd36;
  localparam logic [7:0] BIT_MARK_MIN   = 8'd4;
  localparam logic [7:0] BIT_MARK_MAX   = 8'd12;
  localparam logic [7:0] BIT0_MIN       = 8'd4;
  localparam logic [7:0] BIT0_MAX       = 8'd12;
  localparam logic [7:0] BIT1_MIN       = 8'd18;
  localparam logic [7:0] BIT1_MAX       = 8'd30;
  function automatic logic in_win(input logic [7:0] d, input logic [7:0] lo, input logic [7:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction
endpackage

// File: rtl/nec_ir_sync.sv
// nec_ir_sync: 2-flop synchronizer for the IR pin, polarity normalised so 1 = burst,
// with single-cycle burst start (rise_o) and burst end (fall_o) pulses.
module nec_ir_sync #(
  parameter logic IR_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ir_i,
  output logic rise_o,
  output logic fall_o
);
  localparam logic IDLE_LVL = IR_ACTIVE_LOW;
  logic s1_q, s2_q, prev_q, burst;
  assign burst  = s2_q ^ IR_ACTIVE_LOW;
  assign rise_o = burst & ~prev_q;
  assign fall_o = ~burst & prev_q;
  // Synchronizer chain plus previous-burst flop for edge detection; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= IDLE_LVL;
      s2_q   <= IDLE_LVL;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= ir_i;
      s2_q   <= s1_q;
      prev_q <= burst;
    end
  end
endmodule

// File: rtl/nec_ir_receiver.sv
// nec_ir_receiver: NEC IR frame decoder (leader, 32 bits LSB first, stop burst) with checksum.
// Optional NEC_REPEAT_EN: decode NEC repeat frames into a repeat_code pulse.
module nec_ir_receiver
  import nec_ir_pkg::*;
#(
  parameter int unsigned TICK_CLKS     = 22500,
  parameter logic        IR_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ir_in,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       repeat_code,
  output logic [7:0] addr,
  output logic [7:0] cmd
);
`ifdef NEC_REPEAT_EN
  localparam logic REPEAT_EN = 1'b1;
`else
  localparam logic REPEAT_EN = 1'b0;
`endif
  localparam int unsigned PRE = TICK_CLKS / 8;
  localparam int          PW  = (PRE > 1) ? $clog2(PRE) : 1;

  logic          rise, fall, any_edge, tick, sat, sum_ok;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    dur_q, dur_d;
  state_e        state_q;
  logic [31:0]   sr_q;
  logic [4:0]    cnt_q;
  logic          pend_q, valid_q, err_q, rep_q;
  logic [7:0]    addr_q, cmd_q;

  nec_ir_sync #(.IR_ACTIVE_LOW(IR_ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ir_i  (ir_in),
    .rise_o(rise),
    .fall_o(fall)
  );

  assign any_edge = rise | fall;
  assign tick     = pre_q == PW'(PRE - 1);
  assign sat      = dur_q == E_SAT;
  assign sum_ok   = (sr_q[15:8] == ~sr_q[7:0]) && (sr_q[31:24] == ~sr_q[23:16]);

  // Next prescaler/duration: the edge cycle is the first clk of the new interval, so dur = clks / PRE.
  always_comb begin
    pre_d = any_edge ? PW'(1) : tick ? '0 : pre_q + 1'b1;
    dur_d = any_edge ? '0 : (tick && !sat) ? dur_q + 8'd1 : dur_q;
  end

  // Prescaler and saturating duration counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
      dur_q <= '0;
    end else begin
      pre_q <= pre_d;
      dur_q <= dur_d;
    end
  end

  // Frame FSM: each interval is judged on the edge that ends it; any bad interval aborts to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rep_q   <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rep_q   <= 1'b0;
      if (!enable) begin
        state_q <= S_IDLE;
        pend_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (rise) state_q <= S_LEAD_MARK;
          S_LEAD_MARK:
            if (fall && in_win(dur_q, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_q <= S_LEAD_SPACE;
            else if (fall || sat) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          S_LEAD_SPACE:
            if (rise && in_win(dur_q, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
              state_q <= S_BIT_MARK;
              cnt_q   <= '0;
            end else if (REPEAT_EN && rise && in_win(dur_q, REP_SPACE_MIN, REP_SPACE_MAX)) state_q <= S_REPEAT;
            else if (rise || sat) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          S_BIT_MARK:
            if (fall && in_win(dur_q, BIT_MARK_MIN, BIT_MARK_MAX)) state_q <= S_BIT_SPACE;
            else if (fall || sat) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          S_BIT_SPACE:
            if (rise && (in_win(dur_q, BIT0_MIN, BIT0_MAX) || in_win(dur_q, BIT1_MIN, BIT1_MAX))) begin
              sr_q    <= {in_win(dur_q, BIT1_MIN, BIT1_MAX), sr_q[31:1]};
              cnt_q   <= cnt_q + 5'd1;
              pend_q  <= cnt_q == 5'd31;
              state_q <= (cnt_q == 5'd31) ? S_STOP : S_BIT_MARK;
            end else if (rise || sat) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          S_STOP:
            if (pend_q) begin
              pend_q  <= 1'b0;
              valid_q <= sum_ok;
              err_q   <= ~sum_ok;
              addr_q  <= sum_ok ? sr_q[7:0] : addr_q;
              cmd_q   <= sum_ok ? sr_q[23:16] : cmd_q;
            end else if (fall) state_q <= S_IDLE;
            else if (sat) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          S_REPEAT:
            if (fall && in_win(dur_q, BIT_MARK_MIN, BIT_MARK_MAX)) begin
              rep_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (fall || sat) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign frame_valid = valid_q;
  assign frame_error = err_q;
  assign repeat_code = rep_q & REPEAT_EN;
  assign addr        = addr_q;
  assign cmd         = cmd_q;
endmodule

// File: tb/tb_nec_ir_receiver.sv
// tb_nec_ir_receiver: directed + randomized NEC frames against a protocol-level reference model.
module tb_nec_ir_receiver;
  localparam int TICK = 16;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       ir_in = 1'b1;
  logic       frame_valid, frame_error, repeat_code;
  logic [7:0] addr, cmd;
  int unsigned cyc = 0, vcnt = 0, ecnt = 0, rcnt = 0, both = 0, vcyc = 0, stop_cyc = 0;
  int unsigned v0, e0, r0;
  int          passed = 0, total = 0, fails = 0;
  logic [7:0]  m_addr = 8'h00, m_cmd = 8'h00;
  logic [31:0] w;

  nec_ir_receiver #(.TICK_CLKS(TICK), .IR_ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .ir_in      (ir_in),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .repeat_code(repeat_code),
    .addr       (addr),
    .cmd        (cmd)
  );

  always #12 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      vcnt = vcnt + 1;
      vcyc = cyc;
    end
    if (frame_error) ecnt = ecnt + 1;
    if (repeat_code) rcnt = rcnt + 1;
    if (frame_valid && frame_error) both = both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int jit();
    return int'($urandom_range(4, 0)) - 2;
  endfunction

  function automatic logic frame_ok(input logic [31:0] f);
    return (f[15:8] == ~f[7:0]) && (f[31:24] == ~f[23:16]);
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic hold(input logic burst, input int n);
    ir_in = ~burst;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] f, input int stretch, input int off_bit);
    hold(1'b1, 16 * TICK);
    hold(1'b0, 8 * TICK);
    for (int i = 0; i < 32; i++) begin
      if (i == off_bit) enable = 1'b0;
      hold(1'b1, TICK + jit());
      hold(1'b0, (i == stretch) ? 4 * TICK : (f[i] ? 3 * TICK : TICK) + jit());
    end
    stop_cyc = cyc;
    hold(1'b1, TICK);
    hold(1'b0, 4 * TICK);
  endtask

  task automatic snap();
    v0 = vcnt;
    e0 = ecnt;
    r0 = rcnt;
  endtask

  task automatic model_frame(input logic [31:0] f);
    if (frame_ok(f)) begin
      m_addr = f[7:0];
      m_cmd  = f[23:16];
    end
  endtask

  task automatic clean_frame(input string tag);
    w = mk(8'($urandom), 8'($urandom));
    snap();
    send_frame(w, -1, -1);
    model_frame(w);
    chk({tag, "_valid"}, vcnt - v0, 1);
    chk({tag, "_addrcmd"}, {addr, cmd}, {m_addr, m_cmd});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {frame_valid, frame_error, repeat_code, addr, cmd}, 0);
    rst_n = 1'b1;
    hold(1'b0, 4 * TICK);

    w = mk(8'h5A, 8'hC3);
    snap();
    send_frame(w, -1, -1);
    model_frame(w);
    chk("t1_valid", vcnt - v0, 1);
    chk("t1_error", ecnt - e0, 0);
    chk("t1_addr", addr, 8'h5A);
    chk("t1_cmd", cmd, 8'hC3);
    chk("t1_latency", vcyc - stop_cyc, 4);

    v0 = vcnt;
    for (int k = 0; k < 20; k++) begin
      w = mk(8'($urandom), 8'($urandom));
      e0 = ecnt;
      send_frame(w, -1, -1);
      model_frame(w);
      chk("t2_addrcmd", {addr, cmd}, {m_addr, m_cmd});
      chk("t2_no_error", ecnt - e0, 0);
    end
    chk("t2_valid_count", vcnt - v0, 20);

    w = {8'hEE, 8'h10, 8'hDE, 8'h21};
    snap();
    send_frame(w, -1, -1);
    model_frame(w);
    chk("t3_error", ecnt - e0, frame_ok(w) ? 0 : 1);
    chk("t3_valid", vcnt - v0, 0);
    chk("t3_addrcmd_kept", {addr, cmd}, {m_addr, m_cmd});

    w = mk(8'h01, 8'h77);
    snap();
    send_frame(w, 9, -1);
    chk("t4_error_seen", ecnt != e0, 1);
    chk("t4_valid", vcnt - v0, 0);
    chk("t4_addrcmd_kept", {addr, cmd}, {m_addr, m_cmd});
    clean_frame("t4_recover");

    snap();
    hold(1'b1, 12 * TICK);
    hold(1'b0, 8 * TICK);
    chk("t5_short_leader_err", ecnt - e0, 1);
    chk("t5_short_leader_valid", vcnt - v0, 0);
    snap();
    hold(1'b1, 700);
    hold(1'b0, 4 * TICK);
    chk("t5_stuck_err", ecnt - e0, 1);
    clean_frame("t5_recover");

    snap();
    hold(1'b1, 16 * TICK);
    hold(1'b0, 4 * TICK);
    hold(1'b1, TICK);
    hold(1'b0, 4 * TICK);
`ifdef NEC_REPEAT_EN
    chk("t6_repeat", rcnt - r0, 1);
    chk("t6_error", ecnt - e0, 0);
`else
    chk("t6_repeat", rcnt - r0, 0);
    chk("t6_error_seen", ecnt != e0, 1);
`endif
    chk("t6_valid", vcnt - v0, 0);
    chk("t6_addrcmd_kept", {addr, cmd}, {m_addr, m_cmd});

    w = mk(8'hA7, 8'h3B);
    snap();
    send_frame(w, -1, 4);
    chk("t7_disabled_pulses", {vcnt - v0, ecnt - e0, rcnt - r0} == 0, 1);
    chk("t7_addrcmd_kept", {addr, cmd}, {m_addr, m_cmd});
    enable = 1'b1;
    hold(1'b0, 4 * TICK);
    clean_frame("t7_reenable");

    snap();
    hold(1'b1, 16 * TICK);
    hold(1'b0, 8 * TICK);
    hold(1'b1, TICK);
    hold(1'b0, TICK / 2);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t8_reset_outputs", {frame_valid, frame_error, repeat_code, addr, cmd}, 0);
    hold(1'b0, 300);
    chk("t8_quiet", {vcnt - v0, ecnt - e0} == 0, 1);
    chk("never_valid_and_error", both, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
